mem_arbiter: RTL
================

# mem_arbiter

Two-cache RAM arbiter for the dual-core build. Sits between two `caches` blocks (core 0 and core 1) and the single `cpu_ram_if` RAM port, and serialises their instruction and data word transfers onto RAM. Data requests beat instruction requests within a core, and fair round-robin applies between cores. Replaces the direct one-cache hookup used in the single-cycle top.

## Interface
Parameters:
- `CPUS`, 2: number of cache ports; only 2 is supported.

Ports (`word_t` = 32 bits, `ramstate_t` from `cpu_types_pkg`: FREE, BUSY, ACCESS, ERROR):
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `nRST`  in  1  reset, asynchronous and active-low.
- `iREN[1:0]`  in  2  instruction read request, per cache.
- `dREN[1:0]`  in  2  data read request, per cache.
- `dWEN[1:0]`  in  2  data write request, per cache.
- `iaddr[1:0]`, `daddr[1:0]`  in  2×32  request addresses.
- `dstore[1:0]`  in  2×32  write data.
- `iwait[1:0]`, `dwait[1:0]`  out  2  stall to requester; low only in its completion cycle.
- `iload[1:0]`, `dload[1:0]`  out  2×32  read data (= `ramload` when owned, else 0).
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ramREN`, `ramWEN`  out  1  RAM strobes; never both high.
- `ramload`  in  32  RAM read data.
- `ramstate`  in  ramstate_t  RAM status.

## Operation
- Requesters are numbered 0 = c0.data, 1 = c0.instr, 2 = c1.data, 3 = c1.instr. A data request is `dREN|dWEN`. `dREN&dWEN` together is treated as a write.
- State machine: IDLE, OWN.
  - IDLE: all RAM strobes low. If any request is active, pick a winner and register `owner`, then go to OWN.
  - OWN: drive `ramaddr`, `ramstore`, `ramREN`/`ramWEN` from `owner`, combinationally.
    - `ramstate==ACCESS`: drop the owner's wait this cycle, present `ramload` on its load output, update the RR pointer, go to IDLE.
    - `ramstate==ERROR`: hold ownership, keep the strobes up (retry), and set `err_seen`.
    - Owner drops its request before ACCESS: go to IDLE with no completion and no RR update.
- Winner selection:
  - The preferred core is `rr` (reset 0). If the preferred core has a request, it wins; otherwise the other core wins.
  - Within the winning core, data beats instruction.
  - After a completion by core k, `rr` becomes the other core.
- A 1-bit internal `err_seen` flag is sticky until reset. It is observable only under MEM_ARB_PERF_EN.
- All waits are high whenever a requester is active and not completing, including every IDLE cycle.

## Timing
- Reset values: state IDLE, `owner` 0, `rr` 0, all waits 1, all loads 0, `ramaddr`/`ramstore` 0, strobes 0.
- Reset asserted mid-transfer: strobes drop immediately (async). The transfer is abandoned, and the requester must re-issue it.
- Latency: request first seen at edge N, strobes valid in cycle N+1, completion in the first OWN cycle with ACCESS. The minimum is 2 cycles from request to wait-low.
- Back-to-back: after completion there is one mandatory IDLE cycle before the next grant, so at most 1 transfer per 2 cycles.
- Requests arriving during OWN are not preempted. They are arbitrated at the next IDLE.
- Simultaneous requests from all four: the order is c0.d, c1.d, c0.i, c1.i, provided each is re-asserted.
- Write data and address must stay stable while the requester's wait is high. The arbiter does not latch them.

## Configuration
- `MEM_ARB_PERF_EN` defined:
  - Adds outputs `grant_cnt[1:0]` (2×32) and `stall_cnt[1:0]` (2×32) plus `err_seen` (1).
  - `grant_cnt[k]` increments on each completion by core k.
  - `stall_cnt[k]` increments on each cycle that core k has an active request with its wait high.
  - Counters reset to 0 and wrap at 2^32.
- Undefined: these ports and their logic are absent. Arbitration behaviour is identical.

## Test plan
- Reset, then c0 `iREN=1` with `iaddr=0x0`, RAM returns ACCESS on the first OWN cycle with `ramload=0x3C010004`. Required: `iwait[0]` low exactly in cycle 2 and `iload[0]=0x3C010004`. All other waits stay high and strobes are 0 in cycle 1.
- c0 `dREN` and `iREN` together, RAM BUSY for 3 cycles then ACCESS. Required: data is served first with `ramaddr=daddr[0]`, and `ramREN` is held 4 cycles. The instruction is granted after one IDLE cycle.
- Both cores issue `dWEN` with `dstore=0xAAAA5555` and `0x12345678` repeatedly. Required: grants alternate c0, c1, c0, c1, with no core served twice in a row while the other waits.
- c1 write with `ramstate=ERROR` for 2 cycles then ACCESS. Required: `ramWEN` is held throughout, `dwait[1]` goes low only on the ACCESS cycle, and `err_seen=1` under MEM_ARB_PERF_EN.
- Owner drops `dREN` while the RAM is BUSY. Required: return to IDLE with strobes low, `rr` unchanged, and the next grant still prefers the same core.
- `nRST` pulsed low mid-OWN. Required: strobes and loads go to 0 asynchronously and all waits go to 1. With MEM_ARB_PERF_EN, counters read 0 afterward.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// -----------
// Two-cache RAM arbiter for the dual-core build. Two caches (core 0 and
// core 1) each present an instruction port and a data port. This block
// serialises their word transfers onto the single RAM port.
//
// Requester numbering, which is also the encoding of `owner`:
//    0 = c0.data, 1 = c0.instr, 2 = c1.data, 3 = c1.instr
//    owner = {core, is_instr}
//
// Arbitration:
//    - Between cores the preferred core is `rr`. If the preferred core has a
//      request it wins, otherwise the other core wins. After a completion by
//      core k, `rr` moves to the other core.
//    - Within the winning core, a data request beats an instruction request.
//    - A data request is dREN|dWEN. dREN and dWEN together mean a write.
//
// Ports:
//    CLK, nRST             clock; asynchronous active-low reset
//    iREN/dREN/dWEN[1:0]   per-cache request strobes
//    iaddr/daddr/dstore    per-cache address and write data (2 x 32 bit)
//    iwait/dwait[1:0]      stall to each requester; low only in its
//                          completion cycle
//    iload/dload           read data; equals ramload while owned, else 0
//    ramaddr/ramstore      RAM address and write data
//    ramREN/ramWEN         RAM strobes; the two are never high together
//    ramload               RAM read data
//    ramstate              RAM status; cpu_types_pkg ramstate_t encoding
//                          (FREE=0, BUSY=1, ACCESS=2, ERROR=3)
//
// Optional feature, enabled with the macro MEM_ARB_PERF_EN:
//    grant_cnt[1:0]        completions per core (wraps at 2^32)
//    stall_cnt[1:0]        cycles per core with an active request whose
//                          wait is high (wraps at 2^32)
//    err_seen              sticky flag, set when an owned transfer sees ERROR
// When the macro is undefined, these ports and their logic are absent.

module mem_arbiter #(
    parameter int CPUS = 2
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [CPUS-1:0]        iREN,
    input  logic [CPUS-1:0]        dREN,
    input  logic [CPUS-1:0]        dWEN,
    input  logic [CPUS-1:0][31:0]  iaddr,
    input  logic [CPUS-1:0][31:0]  daddr,
    input  logic [CPUS-1:0][31:0]  dstore,
    output logic [CPUS-1:0]        iwait,
    output logic [CPUS-1:0]        dwait,
    output logic [CPUS-1:0][31:0]  iload,
    output logic [CPUS-1:0][31:0]  dload,
    output logic [31:0]            ramaddr,
    output logic [31:0]            ramstore,
    output logic                   ramREN,
    output logic                   ramWEN,
    input  logic [31:0]            ramload,
    input  logic [1:0]             ramstate
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [CPUS-1:0][31:0]  grant_cnt,
    output logic [CPUS-1:0][31:0]  stall_cnt,
    output logic                   err_seen
`endif
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [1:0]       owner;
    logic             rr;

    logic [CPUS-1:0]  dreq;
    logic [CPUS-1:0]  core_req;
    logic             win_core;
    logic             win_instr;
    logic             owner_core;
    logic             owner_req;
    logic             complete;

    assign owner_core = owner[1];

    // Request summary and winner selection. The winner is only used on an
    // IDLE cycle with at least one request, so the "other core" fallback is
    // always a core that actually has a request there.
    always_comb begin
        dreq      = dREN | dWEN;
        core_req  = dreq | iREN;
        win_core  = core_req[rr] ? rr : ~rr;
        win_instr = ~dreq[win_core];
    end

    // Next-state and output logic. In OWN the RAM port is a combinational
    // view of the owner's request, so a requester that lowers its strobe
    // also drops the RAM strobe in that same cycle. An ERROR status is a
    // retry: ownership and strobes stay as they are until ACCESS arrives or
    // the owner gives up.
    always_comb begin
        next_state = state;
        iwait      = '1;
        dwait      = '1;
        iload      = '0;
        dload      = '0;
        ramaddr    = '0;
        ramstore   = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        owner_req  = 1'b0;
        complete   = 1'b0;

        case (state)
            IDLE: begin
                if (|core_req) begin
                    next_state = OWN;
                end
            end

            OWN: begin
                if (owner[0]) begin
                    owner_req          = iREN[owner_core];
                    ramaddr            = iaddr[owner_core];
                    ramREN             = iREN[owner_core];
                    iload[owner_core]  = ramload;
                end else begin
                    owner_req          = dreq[owner_core];
                    ramaddr            = daddr[owner_core];
                    ramstore           = dstore[owner_core];
                    ramWEN             = dWEN[owner_core];
                    ramREN             = dREN[owner_core] & ~dWEN[owner_core];
                    dload[owner_core]  = ramload;
                end

                if (!owner_req) begin
                    next_state = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    complete   = 1'b1;
                    next_state = IDLE;
                    if (owner[0]) begin
                        iwait[owner_core] = 1'b0;
                    end else begin
                        dwait[owner_core] = 1'b0;
                    end
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State, owner and round-robin registers. The owner is captured on the
    // grant edge. The preferred core moves only on a real completion; an
    // abandoned transfer leaves `rr` alone, so the same core keeps its turn.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            owner <= 2'd0;
            rr    <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && (|core_req)) begin
                owner <= {win_core, win_instr};
            end
            if (complete) begin
                rr <= ~owner_core;
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    localparam logic [1:0] RAM_ERROR = 2'd3;

    logic [CPUS-1:0] stall;

    // A core counts as stalled in any cycle where one of its active
    // requests sees its wait high. This includes its second port while the
    // first one completes.
    always_comb begin
        stall = (dreq & dwait) | (iREN & iwait);
    end

    // Performance counters and the sticky error flag. The counters wrap
    // naturally at 2^32.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
            err_seen  <= 1'b0;
        end else begin
            if (complete) begin
                grant_cnt[owner_core] <= grant_cnt[owner_core] + 32'd1;
            end
            for (int k = 0; k < CPUS; k++) begin
                if (stall[k]) begin
                    stall_cnt[k] <= stall_cnt[k] + 32'd1;
                end
            end
            if (state == OWN && owner_req && ramstate == RAM_ERROR) begin
                err_seen <= 1'b1;
            end
        end
    end
`endif

endmodule
